// File: rtl/dma_mem_probe_collector_if.sv
// Snoop bus, probe configuration and the scoreboard output stream for dma_mem_probe_collector.
interface dma_mem_probe_collector_if #(
  parameter int NUM_LANES   = 32,
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                             cfg__probe__enable;
  logic [1:0]                       cfg__probe__mode;
  logic [NUM_LANES-1:0]             dma__memc__write_valid;
  logic [NUM_LANES-1:0]             memc__dma__write_ready;
  logic [NUM_LANES*ADDR_WIDTH-1:0]  dma__memc__write_address;
  logic [NUM_LANES*DATA_WIDTH-1:0]  dma__memc__write_data;
  logic [NUM_LANES-1:0]             dma__memc__read_valid;
  logic [NUM_LANES-1:0]             memc__dma__read_ready;
  logic [NUM_LANES*ADDR_WIDTH-1:0]  dma__memc__read_address;
  logic                             probe__tb__valid;
  logic                             tb__probe__ready;
  logic [LANE_W-1:0]                probe__tb__lane;
  logic                             probe__tb__is_read;
  logic [ADDR_WIDTH-1:0]            probe__tb__address;
  logic [DATA_WIDTH-1:0]            probe__tb__data;
  logic [NUM_LANES-1:0]             probe__tb__overflow;
  logic [COUNT_WIDTH-1:0]           probe__tb__count;

  modport slave (
    input  cfg__probe__enable, cfg__probe__mode,
    input  dma__memc__write_valid, memc__dma__write_ready,
    input  dma__memc__write_address, dma__memc__write_data,
    input  dma__memc__read_valid, memc__dma__read_ready, dma__memc__read_address,
    input  tb__probe__ready,
    output probe__tb__valid, probe__tb__lane, probe__tb__is_read,
    output probe__tb__address, probe__tb__data, probe__tb__overflow, probe__tb__count
  );

  modport master (
    output cfg__probe__enable, cfg__probe__mode,
    output dma__memc__write_valid, memc__dma__write_ready,
    output dma__memc__write_address, dma__memc__write_data,
    output dma__memc__read_valid, memc__dma__read_ready, dma__memc__read_address,
    output tb__probe__ready,
    input  probe__tb__valid, probe__tb__lane, probe__tb__is_read,
    input  probe__tb__address, probe__tb__data, probe__tb__overflow, probe__tb__count
  );
endinterface

// File: rtl/dma_mem_probe_collector.sv
// Per-lane capture FIFOs for DMA<->memc write/read-request handshakes, merged round-robin
// into one registered valid/ready stream with sticky per-lane drop flags and a delivered count.
module dma_mem_probe_lane #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int EW = 1 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  input  logic                  en_write,
  input  logic                  en_read,
  input  logic                  write_fire,
  input  logic                  read_fire,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_address,
  input  logic                  pop,
  output logic                  not_empty,
  output logic [EW-1:0]         head,
  output logic                  overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic          w, r, push_req, full, do_push, do_pop, drop;
  logic [EW-1:0] push_entry;

  assign w        = en_write && write_fire;
  assign r        = en_read && read_fire;
  assign push_req = w || r;
  assign full     = (cnt == FULL_CNT);
  assign do_pop   = pop && (cnt != '0);
  // A full FIFO still accepts when its head leaves on the same edge.
  assign do_push  = push_req && (!full || do_pop);
  // Write wins a same-cycle collision; the lost read counts as a drop.
  assign drop     = (w && r) || (push_req && !do_push);
  assign push_entry = w ? {1'b0, write_address, write_data}
                        : {1'b1, read_address, {DATA_WIDTH{1'b0}}};

  assign not_empty = (cnt != '0);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

module dma_mem_probe_collector #(
  parameter int NUM_LANES   = 32,
  parameter int ADDR_WIDTH  = 24,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 8,
  parameter int COUNT_WIDTH = 32
) (
  input logic                     clk,
  input logic                     reset_poweron,
  dma_mem_probe_collector_if.slave bus
);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef struct packed {
    logic                  is_read;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [NUM_LANES-1:0] not_empty, pop, ovf;
  entry_t [NUM_LANES-1:0] head;
  logic en_write, en_read;

  assign en_write = bus.cfg__probe__enable && bus.cfg__probe__mode[0];
  assign en_read  = bus.cfg__probe__enable && bus.cfg__probe__mode[1];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dma_mem_probe_lane #(
      .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) u_lane (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .en_write      (en_write),
      .en_read       (en_read),
      .write_fire    (bus.dma__memc__write_valid[i] && bus.memc__dma__write_ready[i]),
      .read_fire     (bus.dma__memc__read_valid[i] && bus.memc__dma__read_ready[i]),
      .write_address (bus.dma__memc__write_address[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .write_data    (bus.dma__memc__write_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .read_address  (bus.dma__memc__read_address[i*ADDR_WIDTH +: ADDR_WIDTH]),
      .pop           (pop[i]),
      .not_empty     (not_empty[i]),
      .head          (head[i]),
      .overflow      (ovf[i])
    );
  end

  logic [LANE_W-1:0]      rr_ptr, grant;
  logic                   grant_vld, can_load;
  int                     idx;
  logic                   out_valid, out_is_read;
  logic [LANE_W-1:0]      out_lane;
  logic [ADDR_WIDTH-1:0]  out_address;
  logic [DATA_WIDTH-1:0]  out_data;
  logic [COUNT_WIDTH-1:0] count;

  // Holding register refills when empty or when its entry leaves this cycle.
  assign can_load = !out_valid || bus.tb__probe__ready;

  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (!grant_vld && not_empty[idx]) begin
        grant_vld = 1'b1;
        grant     = LANE_W'(idx);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant_vld && can_load) pop[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      rr_ptr      <= '0;
      out_valid   <= 1'b0;
      out_is_read <= 1'b0;
      out_lane    <= '0;
      out_address <= '0;
      out_data    <= '0;
      count       <= '0;
    end else begin
      if (can_load) begin
        out_valid <= grant_vld;
        if (grant_vld) begin
          out_lane    <= grant;
          out_is_read <= head[grant].is_read;
          out_address <= head[grant].address;
          out_data    <= head[grant].data;
          rr_ptr      <= (grant == LANE_W'(NUM_LANES-1)) ? '0 : grant + 1'b1;
        end
      end
      if (out_valid && bus.tb__probe__ready && (count != '1)) count <= count + 1'b1;
    end
  end

  assign bus.probe__tb__valid    = out_valid;
  assign bus.probe__tb__lane     = out_lane;
  assign bus.probe__tb__is_read  = out_is_read;
  assign bus.probe__tb__address  = out_address;
  assign bus.probe__tb__data     = out_data;
  assign bus.probe__tb__overflow = ovf;
  assign bus.probe__tb__count    = count;
endmodule
